// File: rtl/array_behavioral.sv
// array_behavioral: simple dual-port flop-based register file.
// One synchronous write port and one registered read port.
// Optional macro ARRAY_WR_BYPASS_EN selects write-first forwarding on a same-address
// write/read. When the macro is undefined, a same-address read returns the old word.
module array_behavioral #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         write_data,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output logic [WIDTH-1:0]         read_data
);

    localparam int unsigned ADDR = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] read_data_q;
    logic [WIDTH-1:0] read_data_d;
    logic             wr_in_range_c;
    logic             rd_in_range_c;
    logic             wr_go_c;

    // Address range checks; every address is legal when DEPTH fills the address space.
    generate
        if (DEPTH == (1 << ADDR)) begin : g_full_range
            assign wr_in_range_c = 1'b1;
            assign rd_in_range_c = 1'b1;
        end else begin : g_partial_range
            assign wr_in_range_c = (32'(write_addr) < DEPTH);
            assign rd_in_range_c = (32'(read_addr) < DEPTH);
        end
    endgenerate

    // Writes to addresses beyond the array are dropped rather than aliased.
    assign wr_go_c = write_en && wr_in_range_c;

    // Next read word: old contents, optionally replaced by the word being written.
    always_comb begin
        read_data_d = '0;
        if (rd_in_range_c) begin
            read_data_d = mem_q[read_addr];
        end
`ifdef ARRAY_WR_BYPASS_EN
        if (wr_go_c && (write_addr == read_addr)) begin
            read_data_d = write_data;
        end
`endif
    end

    // Storage array: cleared asynchronously, written on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_go_c) begin
            mem_q[write_addr] <= write_data;
        end
    end

    // Registered read port, active every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_array_behavioral.sv
// Testbench for array_behavioral: a DEPTH=4 instance and a DEPTH=5 instance
// checked against a word-array reference model.
module tb_array_behavioral;

    logic       clk;
    logic       rst_n;

    logic [7:0] a_wd, a_rd;
    logic [1:0] a_wa, a_ra;
    logic       a_we;

    logic [7:0] b_wd, b_rd;
    logic [2:0] b_wa, b_ra;
    logic       b_we;

    int vectors;
    int miscompares;

    logic [7:0] ma [4];
    logic [7:0] mb [5];
    logic [7:0] exp_a;
    logic [7:0] exp_b;

    array_behavioral #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_data (a_wd),
        .write_addr (a_wa),
        .write_en   (a_we),
        .read_addr  (a_ra),
        .read_data  (a_rd)
    );

    array_behavioral #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_data (b_wd),
        .write_addr (b_wa),
        .write_en   (b_we),
        .read_addr  (b_ra),
        .read_data  (b_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) ma[i] = 8'h00;
        for (int i = 0; i < 5; i++) mb[i] = 8'h00;
        exp_a = 8'h00;
        exp_b = 8'h00;
    endtask

    // One rising edge; the model consumes the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        exp_a = (int'(a_ra) < 4) ? ma[a_ra] : 8'h00;
        exp_b = (int'(b_ra) < 5) ? mb[b_ra] : 8'h00;
`ifdef ARRAY_WR_BYPASS_EN
        if (a_we === 1'b1 && a_wa == a_ra && int'(a_wa) < 4) exp_a = a_wd;
        if (b_we === 1'b1 && b_wa == b_ra && int'(b_wa) < 5) exp_b = b_wd;
`endif
        if (a_we === 1'b1 && int'(a_wa) < 4) ma[a_wa] = a_wd;
        if (b_we === 1'b1 && int'(b_wa) < 5) mb[b_wa] = b_wd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (a_rd !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: read_data=%h expected=%h", a_rd, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_ra = 2'(i);
            tick();
            vectors++;
            if (a_rd !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d: read_data=%h expected=%h", i, a_rd, 8'h00);
            end
        end
    endtask

    task automatic test_fill_read();
        a_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_wa = 2'(i);
            a_wd = 8'(i * 8'h11);
            tick();
        end
        a_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_ra = 2'(i);
            tick();
            vectors++;
            if (a_rd !== 8'(i * 8'h11)) begin
                miscompares++;
                $display("FAIL fill_read addr=%0d: read_data=%h expected=%h", i, a_rd, 8'(i * 8'h11));
            end
        end
    endtask

    task automatic test_hold();
        a_we = 1'b0;
        a_wd = 8'hFF;
        a_wa = 2'd2;
        a_ra = 2'd2;
        tick();
        tick();
        vectors++;
        if (a_rd !== 8'h22) begin
            miscompares++;
            $display("FAIL hold: read_data=%h expected=%h", a_rd, 8'h22);
        end
    endtask

    task automatic test_collision();
        logic [7:0] first_exp;
`ifdef ARRAY_WR_BYPASS_EN
        first_exp = 8'hA5;
`else
        first_exp = 8'h11;
`endif
        a_we = 1'b1;
        a_wa = 2'd1;
        a_ra = 2'd1;
        a_wd = 8'hA5;
        tick();
        vectors++;
        if (a_rd !== first_exp) begin
            miscompares++;
            $display("FAIL collision_same_edge: read_data=%h expected=%h", a_rd, first_exp);
        end
        a_we = 1'b0;
        tick();
        vectors++;
        if (a_rd !== 8'hA5) begin
            miscompares++;
            $display("FAIL collision_next_edge: read_data=%h expected=%h", a_rd, 8'hA5);
        end
    endtask

    task automatic test_reset_mid();
        a_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_wa = 2'(i);
            a_wd = 8'(i * 8'h11);
            tick();
        end
        a_wa = 2'd3;
        a_wd = 8'h5A;
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (a_rd !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_async: read_data=%h expected=%h", a_rd, 8'h00);
        end
        #1 rst_n = 1'b1;
        a_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_ra = 2'(i);
            tick();
            vectors++;
            if (a_rd !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_mid_read addr=%0d: read_data=%h expected=%h", i, a_rd, 8'h00);
            end
        end
    endtask

    task automatic test_out_of_range();
        b_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_wa = 3'(i);
            b_wd = 8'($urandom_range(255));
            tick();
        end
        b_wa = 3'd6;
        b_wd = 8'h77;
        tick();
        b_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_ra = 3'(i);
            tick();
            vectors++;
            if (b_rd !== exp_b) begin
                miscompares++;
                $display("FAIL oor_unchanged addr=%0d: read_data=%h expected=%h", i, b_rd, exp_b);
            end
        end
        b_ra = 3'd6;
        tick();
        vectors++;
        if (b_rd !== 8'h00) begin
            miscompares++;
            $display("FAIL oor_read addr=6: read_data=%h expected=%h", b_rd, 8'h00);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            a_we = 1'($urandom_range(1));
            a_wa = 2'($urandom_range(3));
            a_ra = ($urandom_range(3) == 0) ? a_wa : 2'($urandom_range(3));
            a_wd = 8'($urandom_range(255));
            b_we = 1'($urandom_range(1));
            b_wa = 3'($urandom_range(7));
            b_ra = ($urandom_range(3) == 0) ? b_wa : 3'($urandom_range(7));
            b_wd = 8'($urandom_range(255));
            tick();
            vectors++;
            if (a_rd !== exp_a) begin
                miscompares++;
                $display("FAIL random_d4 cycle=%0d: read_data=%h expected=%h", n, a_rd, exp_a);
            end
            vectors++;
            if (b_rd !== exp_b) begin
                miscompares++;
                $display("FAIL random_d5 cycle=%0d: read_data=%h expected=%h", n, b_rd, exp_b);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a_we = 1'b0; a_wa = '0; a_ra = '0; a_wd = '0;
        b_we = 1'b0; b_wa = '0; b_ra = '0; b_wd = '0;
        test_reset();
        test_fill_read();
        test_hold();
        test_collision();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
